// File: rtl/a_unit_if.sv
// a_unit_if: signal bundle for the a_unit truth-table function block.
// Optional coverage signals exist only when A_UNIT_COVERAGE_EN is defined.
// master = side that drives the function inputs and table load,
// slave  = the a_unit itself.
interface a_unit_if;
  logic        a;
  logic        b;
  logic        c;
  logic        d;
  logic        tt_we;
  logic [15:0] tt_data;
  logic        y_comb;
  logic        y;
  logic [15:0] tt_q;
`ifdef A_UNIT_COVERAGE_EN
  logic [15:0] cov;
  logic        cov_full;
`endif

  modport master (
`ifdef A_UNIT_COVERAGE_EN
    input  cov,
    input  cov_full,
`endif
    output a,
    output b,
    output c,
    output d,
    output tt_we,
    output tt_data,
    input  y_comb,
    input  y,
    input  tt_q
  );

  modport slave (
`ifdef A_UNIT_COVERAGE_EN
    output cov,
    output cov_full,
`endif
    input  a,
    input  b,
    input  c,
    input  d,
    input  tt_we,
    input  tt_data,
    output y_comb,
    output y,
    output tt_q
  );
endinterface

// File: rtl/a_unit.sv
// a_unit: 4-input Boolean function y = f(a,b,c,d) defined by a reloadable
// 16-entry truth table indexed by {a,b,c,d} (a is the MSB).
// y_comb is the direct table lookup, y is the same value registered once.
// Optional feature macro: A_UNIT_COVERAGE_EN adds sticky per-index coverage
// (cov) and a registered all-covered flag (cov_full).
module a_unit #(
  parameter logic [15:0] TRUTH_TABLE = 16'hF888
) (
  input  logic     clk,
  input  logic     rst,
  a_unit_if.slave  bus
);

  // Table lookup kept as a function so the registered and combinational
  // paths are guaranteed to decode the index identically.
  function automatic logic tt_lookup(input logic [15:0] tt, input logic [3:0] idx);
    logic v;
    v = tt[idx];
    return v;
  endfunction

  logic [3:0]  w_idx;
  logic        w_y_comb;
  logic [15:0] r_tt_q;
  logic        r_y;

  // Form the table index from the function inputs and look up the result.
  always_comb begin
    w_idx    = {bus.a, bus.b, bus.c, bus.d};
    w_y_comb = tt_lookup(r_tt_q, w_idx);
  end

  // Core state: the table register and the registered result. y samples the
  // old table on a load edge because the lookup reads r_tt_q before update.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tt_q <= TRUTH_TABLE;
      r_y    <= 1'b0;
    end else begin
      r_y <= w_y_comb;
      if (bus.tt_we) begin
        r_tt_q <= bus.tt_data;
      end else begin
        r_tt_q <= r_tt_q;
      end
    end
  end

  assign bus.y_comb = w_y_comb;
  assign bus.y      = r_y;
  assign bus.tt_q   = r_tt_q;

`ifdef A_UNIT_COVERAGE_EN
  logic [15:0] r_cov;
  logic        r_cov_full;

  // Sticky per-index coverage; cov_full reflects the previous edge's cov,
  // so it rises one edge after the last missing index is recorded.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cov      <= 16'h0000;
      r_cov_full <= 1'b0;
    end else begin
      r_cov_full   <= &r_cov;
      r_cov[w_idx] <= 1'b1;
    end
  end

  assign bus.cov      = r_cov;
  assign bus.cov_full = r_cov_full;
`endif

endmodule

// File: tb/tb_a_unit.sv
// tb_a_unit: self-checking bench for a_unit. Inputs change on the falling
// edge; y_comb is checked 1 ns later, y/tt_q 1 ns after the rising edge.
// A reference table model produces expected y values into a scoreboard queue.
module tb_a_unit;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  logic [15:0] m_tt;
  logic        e_comb;
  logic        q_y[$];
  logic        exp_y;
`ifdef A_UNIT_COVERAGE_EN
  logic [15:0] m_cov;
  logic        m_full;
`endif

  a_unit_if u_bus ();

  a_unit #(.TRUTH_TABLE(16'hF888)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of stimulus at the falling edge and record what the DUT
  // should produce: e_comb for now, y into the scoreboard for the next edge.
  task automatic drive(input logic [3:0] idx, input logic we,
                       input logic [15:0] data, input logic r);
    @(negedge clk);
    {u_bus.a, u_bus.b, u_bus.c, u_bus.d} = idx;
    u_bus.tt_we   = we;
    u_bus.tt_data = data;
    rst           = r;
    e_comb = m_tt[idx];
    q_y.push_back(r ? 1'b0 : m_tt[idx]);
`ifdef A_UNIT_COVERAGE_EN
    if (r) begin
      m_cov  = 16'h0000;
      m_full = 1'b0;
    end else begin
      m_full     = &m_cov;
      m_cov[idx] = 1'b1;
    end
`endif
    if (r) m_tt = 16'hF888;
    else if (we) m_tt = data;
  endtask

  task automatic pop_exp();
    if (q_y.size() == 0) begin
      exp_y = 1'bx;
    end else begin
      exp_y = q_y.pop_front();
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(4'd5, 1'b1, 16'h1234, 1'b1);
      @(posedge clk); #1;
      pop_exp();
      n_total++;
      if (u_bus.y !== 1'b0) $display("FAIL reset_y: got %b want 0", u_bus.y);
      else n_pass++;
      n_total++;
      if (u_bus.tt_q !== 16'hF888) $display("FAIL reset_tt_q: got %h want F888", u_bus.tt_q);
      else n_pass++;
    end
  endtask

  task automatic test_sweep();
    logic [15:0] sweep_exp;
    sweep_exp = 16'b1111_1000_1000_1000; // bit i = expected f(i)
    for (int i = 0; i < 16; i++) begin
      drive(i[3:0], 1'b0, 16'h0000, 1'b0);
      #1;
      n_total++;
      if (u_bus.y_comb !== sweep_exp[i])
        $display("FAIL sweep_y_comb idx=%0d: got %b want %b", i, u_bus.y_comb, sweep_exp[i]);
      else n_pass++;
      @(posedge clk); #1;
      pop_exp();
      n_total++;
      if (u_bus.y !== exp_y || u_bus.y !== sweep_exp[i])
        $display("FAIL sweep_y idx=%0d: got %b want %b", i, u_bus.y, sweep_exp[i]);
      else n_pass++;
    end
  endtask

  task automatic test_load();
    logic [3:0] seq [4];
    logic       want [4];
    seq  = '{4'd15, 4'd3, 4'd15, 4'd12};
    want = '{1'b1, 1'b0, 1'b1, 1'b0};
    drive(4'd15, 1'b1, 16'h8000, 1'b0);
    @(posedge clk); #1;
    pop_exp();
    n_total++;
    if (u_bus.y !== 1'b1 || u_bus.y !== exp_y)
      $display("FAIL load_edge_y: got %b want 1", u_bus.y);
    else n_pass++;
    n_total++;
    if (u_bus.tt_q !== 16'h8000) $display("FAIL load_tt_q: got %h want 8000", u_bus.tt_q);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      drive(seq[i], 1'b0, 16'h0000, 1'b0);
      #1;
      n_total++;
      if (u_bus.y_comb !== want[i])
        $display("FAIL load_y_comb idx=%0d: got %b want %b", seq[i], u_bus.y_comb, want[i]);
      else n_pass++;
      @(posedge clk); #1;
      pop_exp();
      n_total++;
      if (u_bus.y !== exp_y)
        $display("FAIL load_y idx=%0d: got %b want %b", seq[i], u_bus.y, exp_y);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    drive(4'd3, 1'b1, 16'h0000, 1'b1);
    @(posedge clk); #1;
    pop_exp();
    n_total++;
    if (u_bus.tt_q !== 16'hF888) $display("FAIL midrst_tt_q: got %h want F888", u_bus.tt_q);
    else n_pass++;
    n_total++;
    if (u_bus.y !== 1'b0) $display("FAIL midrst_y: got %b want 0", u_bus.y);
    else n_pass++;
    drive(4'd3, 1'b0, 16'h0000, 1'b0);
    #1;
    n_total++;
    if (u_bus.y_comb !== 1'b1) $display("FAIL midrst_y_comb: got %b want 1", u_bus.y_comb);
    else n_pass++;
    @(posedge clk); #1;
    pop_exp();
    n_total++;
    if (u_bus.y !== 1'b1 || u_bus.y !== exp_y) $display("FAIL midrst_idx3_y: got %b want 1", u_bus.y);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic prev_comb;
    logic y_early;
    for (int i = 0; i < 8; i++) begin
      drive(4'd12, 1'b1, (i % 2 == 0) ? 16'h0000 : 16'hFFFF, 1'b0);
      #1;
      prev_comb = u_bus.y_comb;
      n_total++;
      if (u_bus.y_comb !== e_comb)
        $display("FAIL b2b_y_comb cyc=%0d: got %b want %b", i, u_bus.y_comb, e_comb);
      else n_pass++;
      @(posedge clk); #1;
      y_early = u_bus.y;
      pop_exp();
      n_total++;
      if (u_bus.y !== exp_y || u_bus.y !== prev_comb)
        $display("FAIL b2b_y cyc=%0d: got %b want %b", i, u_bus.y, exp_y);
      else n_pass++;
      #3;
      n_total++;
      if (u_bus.y !== y_early)
        $display("FAIL b2b_y_stable cyc=%0d: got %b want %b", i, u_bus.y, y_early);
      else n_pass++;
    end
  endtask

`ifdef A_UNIT_COVERAGE_EN
  task automatic test_coverage();
    drive(4'd0, 1'b0, 16'h0000, 1'b1);
    @(posedge clk); #1;
    pop_exp();
    for (int i = 0; i < 15; i++) begin
      drive(i[3:0], (i == 7), 16'h1111, 1'b0);
      @(posedge clk); #1;
      pop_exp();
    end
    n_total++;
    if (u_bus.cov !== 16'h7FFF || u_bus.cov !== m_cov)
      $display("FAIL cov_15: got %h want 7FFF", u_bus.cov);
    else n_pass++;
    n_total++;
    if (u_bus.cov_full !== 1'b0) $display("FAIL cov_full_15: got %b want 0", u_bus.cov_full);
    else n_pass++;
    drive(4'd15, 1'b0, 16'h0000, 1'b0);
    @(posedge clk); #1;
    pop_exp();
    n_total++;
    if (u_bus.cov !== 16'hFFFF) $display("FAIL cov_16: got %h want FFFF", u_bus.cov);
    else n_pass++;
    n_total++;
    if (u_bus.cov_full !== m_full) $display("FAIL cov_full_edge: got %b want %b", u_bus.cov_full, m_full);
    else n_pass++;
    drive(4'd2, 1'b0, 16'h0000, 1'b0);
    @(posedge clk); #1;
    pop_exp();
    n_total++;
    if (u_bus.cov_full !== 1'b1) $display("FAIL cov_full_next: got %b want 1", u_bus.cov_full);
    else n_pass++;
    drive(4'd2, 1'b0, 16'h0000, 1'b1);
    @(posedge clk); #1;
    pop_exp();
    n_total++;
    if (u_bus.cov !== 16'h0000 || u_bus.cov_full !== 1'b0)
      $display("FAIL cov_rst: got %h/%b want 0000/0", u_bus.cov, u_bus.cov_full);
    else n_pass++;
  endtask
`endif

  initial begin
    n_pass  = 0;
    n_total = 0;
    m_tt    = 16'hF888;
`ifdef A_UNIT_COVERAGE_EN
    m_cov   = 16'h0000;
    m_full  = 1'b0;
`endif
    rst           = 1'b1;
    u_bus.a       = 1'b0;
    u_bus.b       = 1'b0;
    u_bus.c       = 1'b0;
    u_bus.d       = 1'b0;
    u_bus.tt_we   = 1'b0;
    u_bus.tt_data = 16'h0000;
    test_reset();
    test_sweep();
    test_load();
    test_reset_mid();
    test_back_to_back();
`ifdef A_UNIT_COVERAGE_EN
    test_coverage();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
